// File: rtl/ms_shift_register.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : ms_shift_register
// Brief    : WIDTH-bit register with complement output, parallel load and
//            multi-cycle serial SHL/SHR/ROTL over a valid/ready handshake.
//            Optional macro ASR_EN makes SHR arithmetic (MSB replicated).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module ms_shift_register #(
    parameter int             WIDTH   = 5,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    localparam int            AMT_W   = $clog2(WIDTH) + 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             VALID,
    output logic             READY,
    input  logic [1:0]       OP,
    input  logic [AMT_W-1:0] AMT,
    input  logic [WIDTH-1:0] D,
    input  logic             SI,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] QN,
    output logic             SO,
    output logic             BUSY,
    output logic             DONE
);

    localparam logic [1:0]       c_OP_LOAD = 2'b00;
    localparam logic [1:0]       c_OP_SHL  = 2'b01;
    localparam logic [1:0]       c_OP_SHR  = 2'b10;
    localparam logic [1:0]       c_OP_ROTL = 2'b11;
    localparam logic [AMT_W-1:0] c_WIDTH   = AMT_W'(WIDTH);
    localparam logic [AMT_W-1:0] c_ONE     = AMT_W'(1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [1:0]       r_op, w_op_nxt;
    logic [AMT_W-1:0] r_count, w_count_nxt;
    logic [WIDTH-1:0] r_q, w_q_nxt;
    logic             r_so, w_so_nxt;
    logic             r_done, w_done_nxt;

    logic             w_accept;
    logic [AMT_W-1:0] w_amt_sat;
    logic             w_shr_msb;

    assign w_accept  = VALID && (r_state == S_IDLE);
    assign w_amt_sat = (AMT > c_WIDTH) ? c_WIDTH : AMT;

`ifdef ASR_EN
    assign w_shr_msb = r_q[WIDTH-1];
`else
    assign w_shr_msb = SI;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_op    <= c_OP_LOAD;
            r_count <= '0;
            r_q     <= RST_VAL;
            r_so    <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_op    <= w_op_nxt;
            r_count <= w_count_nxt;
            r_q     <= w_q_nxt;
            r_so    <= w_so_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_op_nxt    = r_op;
        w_count_nxt = r_count;
        w_q_nxt     = r_q;
        w_so_nxt    = r_so;
        w_done_nxt  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (OP == c_OP_LOAD) begin
                        w_q_nxt    = D;
                        w_done_nxt = 1'b1;
                    end else if (w_amt_sat == '0) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        // Q holds on the accept edge; shifting starts next edge.
                        w_state_nxt = S_SHIFT;
                        w_op_nxt    = OP;
                        w_count_nxt = w_amt_sat;
                    end
                end
            end
            S_SHIFT: begin
                case (r_op)
                    c_OP_SHL: begin
                        w_q_nxt  = {r_q[WIDTH-2:0], SI};
                        w_so_nxt = r_q[WIDTH-1];
                    end
                    c_OP_SHR: begin
                        w_q_nxt  = {w_shr_msb, r_q[WIDTH-1:1]};
                        w_so_nxt = r_q[0];
                    end
                    c_OP_ROTL: begin
                        w_q_nxt  = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
                        w_so_nxt = r_q[WIDTH-1];
                    end
                    default: begin
                        w_q_nxt  = r_q;
                        w_so_nxt = r_so;
                    end
                endcase
                w_count_nxt = r_count - c_ONE;
                if (r_count == c_ONE) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign READY = (r_state == S_IDLE);
    assign BUSY  = (r_state == S_SHIFT);
    assign Q     = r_q;
    assign QN    = ~r_q;
    assign SO    = r_so;
    assign DONE  = r_done;

endmodule
`default_nettype wire

// File: doc/ms_shift_register.md
Name: ms_shift_register

Overview:
- Parametrised successor to the single-bit master-slave D flip-flop: a WIDTH-bit edge-triggered register with complement output, parallel load, and multi-cycle serial shift/rotate commands.
- Holds and conditions CLA operands, e.g. pre-shifting an operand before the 5-bit adder.
- Commands arrive over a valid/ready handshake.
- A shift of k positions executes one bit per clock; BUSY and DONE report progress.

Parameters:
- WIDTH, 5, register width in bits (>=2).
- RST_VAL, 0, value loaded into Q on reset (WIDTH bits).
- AMT_W, $clog2(WIDTH)+1, width of the shift-amount field (localparam, derived, not overridable).

Ports:
- CLK  input  1  clock; all state updates on posedge.
- RST  input  1  reset, asynchronous, active-high.
- VALID  input  1  command valid.
- READY  output  1  command accepted when VALID && READY at posedge.
- OP  input  2  00 LOAD, 01 SHL, 10 SHR, 11 ROTL.
- AMT  input  AMT_W  shift count for SHL/SHR/ROTL; ignored for LOAD.
- D  input  WIDTH  parallel load data.
- SI  input  1  serial input bit.
- Q  output  WIDTH  register contents.
- QN  output  WIDTH  bitwise complement of Q, always ~Q.
- SO  output  1  last bit shifted/rotated out.
- BUSY  output  1  multi-cycle shift in progress.
- DONE  output  1  one-cycle pulse on command completion.

Behaviour:
- Reset:
  - RST high forces Q=RST_VAL, QN=~RST_VAL, SO=0, BUSY=0, DONE=0, count=0, state IDLE, READY=1.
  - Reset takes effect immediately, including mid-shift. The in-flight command is discarded and no DONE is generated.
- States and READY:
  - States are IDLE and SHIFT. READY = (state==IDLE) and BUSY = (state==SHIFT), both combinational from state.
- LOAD accepted:
  - Q<=D at the accepting edge; SO unchanged.
  - DONE=1 for the following cycle; state stays IDLE.
- SHL/SHR/ROTL accepted with AMT=0:
  - Q and SO unchanged; DONE=1 for the following cycle; state stays IDLE.
- SHL/SHR/ROTL accepted with AMT=k>0:
  - Effective count is min(k, WIDTH); AMT values above WIDTH saturate to WIDTH.
  - At the accepting edge: latch op and count, go to SHIFT. Q does not change on this edge.
  - Each following edge in SHIFT shifts Q by one bit and decrements count.
  - SI is sampled at every shift edge.
  - On the edge where count goes 1->0: state goes to IDLE and DONE=1 for the following cycle.
  - Latency from accept edge to final Q is k' edges, where k' is the effective count; BUSY is high for k' cycles.
- Per-bit operations:
  - SHL: Q<={Q[WIDTH-2:0],SI}, SO<=Q[WIDTH-1].
  - SHR: Q<={SI,Q[WIDTH-1:1]}, SO<=Q[0].
  - ROTL: Q<={Q[WIDTH-2:0],Q[WIDTH-1]}, SO<=Q[WIDTH-1]. SI is ignored.
  - ROTL by WIDTH returns the original Q.
- Handshake:
  - VALID while BUSY is ignored (not accepted, not queued).
  - A command may be accepted in the same cycle DONE is high.
  - Back-to-back LOADs complete one per cycle.
- Glitch-freedom: Q, QN, SO and DONE are registered outputs, so they carry no combinational paths from inputs.

Optional Feature:
- Macro ASR_EN.
- Defined: SHR is arithmetic, so the vacated MSB takes the current Q[WIDTH-1] and SI is ignored for SHR.
- Undefined: SHR is logical, so the MSB takes SI as specified above.
- SHL and ROTL are identical in both builds.

Test Plan:
- Reset mid-operation: WIDTH=5, RST_VAL=0. Accept SHL AMT=3, then assert RST after 1 shift -> Q=00000, QN=11111, SO=0, BUSY=0, READY=1, no DONE pulse.
- Load: VALID, OP=LOAD, D=10110 -> Q=10110 and QN=01001 after the accept edge, DONE high exactly 1 cycle, READY stays 1. A second LOAD D=00011 on the next cycle -> Q=00011.
- Shift left: Q=10110, SHL AMT=2, SI=1.
  - First shift edge -> Q=01101, SO=1.
  - Second shift edge -> Q=11011, SO=0.
  - BUSY high 2 cycles; DONE pulses with Q=11011; VALID asserted while BUSY is not accepted.
- Rotate saturation: Q=10110, ROTL AMT=7 -> BUSY exactly 5 cycles, final Q=10110, DONE once.
- Zero shift: SHR AMT=0 -> Q unchanged, BUSY never high, DONE 1 cycle after accept. Then SHR AMT=2, SI=0 from Q=10110 -> Q=00101, SO=1.
- ASR_EN build: Q=10110, SHR AMT=2, SI=0 -> Q=11011 then 11101, SO=1. The same stimulus without the macro -> 00101.
